output_uart_tx: RTL and testbench

Serial output stage downstream of the SAP output register. Captures the 16-bit result value on a load strobe and transmits it over a standard 8N1 UART line as four uppercase ASCII hex characters, MSB nibble first, optionally followed by CR LF. This gives the processor a bench- and board-visible result stream without a binary LED display.

---
 rtl/output_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_output_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/output_uart_tx.sv
// output_uart_tx -- serial result stream for the SAP output register.
//
// Latches the 16-bit result on a load strobe and sends it as four uppercase
// ASCII hex characters (MSB nibble first) on an 8N1 UART line. CR LF can be
// appended to each message.
//
// Build option: define OUTPUT_UART_PARITY_EN to insert an even-parity bit
// after the data bits, which gives 8E1 frames of 11 bits.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2 or more)
//   SEND_CRLF     1: append 0x0D 0x0A after the hex characters
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous reset, active low
//   load     one-cycle strobe; accepted only while busy is low
//   data_in  16-bit value, captured on an accepted load
//   tx       UART serial line, idles high
//   busy     high while a message is in flight (registered)
//   dropped  one-cycle pulse after a load that arrived while busy
module output_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit SEND_CRLF    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        dropped
);

    localparam int             BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_CHAR = SEND_CRLF ? 3'd5 : 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef OUTPUT_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [2:0]    char_idx, char_idx_nxt;
    logic [15:0]   shadow, shadow_nxt;
    logic          busy_nxt;
    logic          baud_done;
    logic [3:0]    nibble;
    logic [7:0]    cur_byte;

    assign baud_done = (baud_cnt == BAUD_LAST);

    // Character currently on the wire, derived from the shadow register.
    always_comb begin
        nibble   = 4'h0;
        cur_byte = 8'h0A;
        case (char_idx)
            3'd0: nibble = shadow[15:12];
            3'd1: nibble = shadow[11:8];
            3'd2: nibble = shadow[7:4];
            3'd3: nibble = shadow[3:0];
            default: nibble = 4'h0;
        endcase
        if (char_idx < 3'd4)
            cur_byte = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                        : (8'h37 + {4'h0, nibble});
        else if (char_idx == 3'd4)
            cur_byte = 8'h0D;
        else
            cur_byte = 8'h0A;
    end

    // Line level is a pure decode of the frame position.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:  tx = 1'b0;
            DATA:   tx = cur_byte[bit_idx];
`ifdef OUTPUT_UART_PARITY_EN
            PARITY: tx = ^cur_byte;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        char_idx_nxt = char_idx;
        shadow_nxt   = shadow;
        busy_nxt     = busy;

        // Every non-idle state lasts exactly one bit time.
        if (state != IDLE)
            baud_cnt_nxt = baud_done ? '0 : baud_cnt + BW'(1);

        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt    = START;
                    shadow_nxt   = data_in;
                    char_idx_nxt = 3'd0;
                    baud_cnt_nxt = '0;
                    busy_nxt     = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef OUTPUT_UART_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
`ifdef OUTPUT_UART_PARITY_EN
            PARITY: begin
                if (baud_done)
                    state_nxt = STOP;
            end
`endif
            STOP: begin
                if (baud_done) begin
                    // No gap between characters: next start bit follows directly.
                    if (char_idx == LAST_CHAR) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt    = START;
                        char_idx_nxt = char_idx + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            char_idx <= 3'd0;
            shadow   <= 16'h0;
            busy     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            char_idx <= char_idx_nxt;
            shadow   <= shadow_nxt;
            busy     <= busy_nxt;
            // busy is the registered value, so a load on the edge where busy
            // falls still counts as dropped.
            dropped  <= load & busy;
        end
    end

endmodule

// File: tb/tb_output_uart_tx.sv
module tb_output_uart_tx;

    localparam int CPB = 16;
`ifdef OUTPUT_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LEN_A = 6 * FB * CPB;   // SEND_CRLF=1 instance
    localparam int LEN_B = 4 * FB * CPB;   // SEND_CRLF=0 instance
    localparam int LOGN  = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_a = 1'b0, load_b = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        tx_a, busy_a, drop_a;
    logic        tx_b, busy_b, drop_b;

    int total = 0;
    int bad   = 0;

    logic tx_log   [2][LOGN];
    logic busy_log [2][LOGN];
    logic drop_log [2][LOGN];

    always #5 clock = ~clock;

    output_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b1)) u_dut_a (
        .clock(clock), .reset(reset), .load(load_a), .data_in(data_in),
        .tx(tx_a), .busy(busy_a), .dropped(drop_a));

    output_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b0)) u_dut_b (
        .clock(clock), .reset(reset), .load(load_b), .data_in(data_in),
        .tx(tx_b), .busy(busy_b), .dropped(drop_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: ASCII for character k of a message carrying v.
    function automatic logic [7:0] exp_char(input logic [15:0] v, input int k);
        int n;
        if (k == 4) return 8'h0D;
        if (k == 5) return 8'h0A;
        n = (v >> (4 * (3 - k))) & 15;
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Present a one-edge load; the next negedge is sample 0 of the message.
    task automatic send(input int sel, input logic [15:0] v);
        @(negedge clock);
        data_in = v;
        if (sel == 0) load_a = 1'b1; else load_b = 1'b1;
        @(posedge clock);
        #1;
        load_a = 1'b0;
        load_b = 1'b0;
        data_in = 16'($urandom);   // must not disturb the message in flight
    endtask

    // Log both DUTs once per cycle; optionally raise load between samples.
    task automatic capture(input int n, input int sel, input int inj_set,
                           input int inj_clr, input logic [15:0] inj_data);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            tx_log[0][i] = tx_a; busy_log[0][i] = busy_a; drop_log[0][i] = drop_a;
            tx_log[1][i] = tx_b; busy_log[1][i] = busy_b; drop_log[1][i] = drop_b;
            if (i == inj_set) begin
                data_in = inj_data;
                if (sel == 0) load_a = 1'b1; else load_b = 1'b1;
            end
            if (i == inj_clr) begin
                load_a = 1'b0;
                load_b = 1'b0;
            end
        end
    endtask

    // Decode a message starting at sample off by mid-bit sampling.
    task automatic check_msg(input string tag, input int sel, input logic [15:0] v, input int off);
        int nch, len, cnt, base;
        logic [7:0] byte_v;
        nch = (sel == 0) ? 6 : 4;
        len = nch * FB * CPB;
        cnt = 0;
        for (int i = off; i < off + len; i++) cnt += int'(busy_log[sel][i]);
        chk($sformatf("%s busy_len", tag), cnt, len);
        chk($sformatf("%s busy_end", tag), busy_log[sel][off + len], 1'b0);
        chk($sformatf("%s first_low", tag), tx_log[sel][off], 1'b0);
        if (off > 0) chk($sformatf("%s pre_idle", tag), tx_log[sel][off - 1], 1'b1);
        for (int k = 0; k < nch; k++) begin
            base = off + k * FB * CPB + CPB / 2;
            chk($sformatf("%s c%0d start", tag, k), tx_log[sel][base], 1'b0);
            for (int b = 0; b < 8; b++) byte_v[b] = tx_log[sel][base + (b + 1) * CPB];
            chk($sformatf("%s c%0d char", tag, k), byte_v, exp_char(v, k));
`ifdef OUTPUT_UART_PARITY_EN
            chk($sformatf("%s c%0d parity", tag, k), tx_log[sel][base + 9 * CPB], ^exp_char(v, k));
`endif
            chk($sformatf("%s c%0d stop", tag, k), tx_log[sel][base + (FB - 1) * CPB], 1'b1);
        end
        chk($sformatf("%s idle_after", tag), tx_log[sel][off + len], 1'b1);
    endtask

    function automatic int count_drops(input int sel, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(drop_log[sel][i]);
        return c;
    endfunction

    initial begin
        logic [15:0] v;
        int cnt;

        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst tx_a", tx_a, 1'b1);
        chk("rst busy_a", busy_a, 1'b0);
        chk("rst drop_a", drop_a, 1'b0);
        chk("rst tx_b", tx_b, 1'b1);
        chk("rst busy_b", busy_b, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // basic message
        send(0, 16'h1234);
        capture(LEN_A + 8, 0, -1, -1, 16'h0);
        check_msg("basic", 0, 16'h1234, 0);
        chk("basic drops", count_drops(0, LEN_A + 8), 0);

        // hex letters, no CR LF
        send(1, 16'hABCD);
        capture(LEN_B + 8, 1, -1, -1, 16'h0);
        check_msg("nocrlf", 1, 16'hABCD, 0);

        // load while busy
        send(0, 16'h00FF);
        capture(LEN_A + 8, 0, 100, 101, 16'h1111);
        check_msg("drop", 0, 16'h00FF, 0);
        chk("drop pulse", drop_log[0][101], 1'b1);
        chk("drop count", count_drops(0, LEN_A + 8), 1);

        // back-to-back: load held across the busy-falling edge
        v = 16'($urandom);
        send(0, v);
        capture(2 * LEN_A + 10, 0, LEN_A - 1, LEN_A + 1, 16'h0001);
        check_msg("b2b first", 0, v, 0);
        check_msg("b2b second", 0, 16'h0001, LEN_A + 1);

        // reset mid-frame
        send(0, 16'h5A5A);
        capture(300, 0, -1, -1, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst tx", tx_a, 1'b1);
        chk("midrst busy", busy_a, 1'b0);
        capture(20, 0, -1, -1, 16'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) cnt += int'(!tx_log[0][i]) + int'(busy_log[0][i]);
        chk("midrst quiet", cnt, 0);
        @(negedge clock);
        reset = 1'b1;
        send(0, 16'h0000);
        capture(LEN_A + 8, 0, -1, -1, 16'h0);
        check_msg("after_rst", 0, 16'h0000, 0);

        // parity corner values (also a plain 8N1 check when parity is off)
        send(0, 16'h0007);
        capture(LEN_A + 8, 0, -1, -1, 16'h0);
        check_msg("p0007", 0, 16'h0007, 0);

        // random values on both instances
        for (int r = 0; r < 3; r++) begin
            v = 16'($urandom);
            send(0, v);
            capture(LEN_A + 8, 0, -1, -1, 16'h0);
            check_msg($sformatf("rnd_a%0d", r), 0, v, 0);
        end
        for (int r = 0; r < 2; r++) begin
            v = 16'($urandom);
            send(1, v);
            capture(LEN_B + 8, 1, -1, -1, 16'h0);
            check_msg($sformatf("rnd_b%0d", r), 1, v, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
